nibble_mac_accumulator: RTL and testbench
=========================================

// Module: nibble_mac_accumulator
// PURPOSE
//  Downstream stage of the nibble-pair multiplier user module: consumes the product of consecutive
//  4-bit operands, accumulates into a saturating 16-bit register, and dumps it byte-serially on
//  io_out. Same 8-in/8-out pin-wrapper footprint; host drives commands on io_in[3:2].
// PARAMETERS
//  ACC_W   16      accumulator width; fixed at 16 (dump format is header + two bytes)
//  HDR_HI  7'h52   upper 7 bits of dump header byte; header = {HDR_HI, ovf} -> 0xA4 / 0xA5
// PORTS
//  io_in[0]    input  1  clock; all state updates on rising edge
//  io_in[1]    input  1  reset; synchronous, active-high
//  io_in[3:2]  input  2  cmd: 00 ACC, 01 HOLD, 10 CLEAR, 11 DUMP
//  io_in[7:4]  input  4  operand nibble stream
//  io_out      output 8  RUN: acc[7:0]; DUMP states: header / acc[15:8] / acc[7:0] (/ parity)
// BEHAVIOUR
//  Reset: nib_q, nib_prev_q, acc, ovf, shadow <= 0; state <= RUN; io_out = 0x00 next cycle.
//  Operand pipe, every edge in every state: nib_q <= io_in[7:4]; nib_prev_q <= nib_q.
//  Product p = nib_q * nib_prev_q (8-bit, unsigned, combinational); max 225.
//  RUN, cmd=00: acc <= min(acc + p, 0xFFFF); ovf <= ovf | carry-out (sticky).
//  RUN, cmd=01: acc, ovf hold.  RUN, cmd=10: acc <= 0, ovf <= 0 (operand pipe unaffected).
//  RUN, cmd=11: shadow <= acc, no accumulate this edge; state -> DUMP_HDR.
//  FSM: RUN -> DUMP_HDR -> DUMP_HI -> DUMP_LO -> RUN (one cycle each, unconditional).
//  io_out (registered state, combinational select): DUMP_HDR {HDR_HI, ovf}; DUMP_HI shadow[15:8];
//   DUMP_LO shadow[7:0]; RUN acc[7:0].
//  During DUMP_*: cmd ignored entirely (no accumulate, no clear); acc and ovf frozen.
//  Saturation: exactly reaching 0xFFFF does not set ovf; any sum > 0xFFFF clamps and sets ovf.
//  At 0xFFFF with p=0: no change, ovf unchanged.
//  Reset mid-dump: state -> RUN, shadow/acc/ovf cleared; remaining dump bytes abandoned.
//  Dump latency: cmd=11 sampled at edge N -> header on io_out after edge N, bytes after N+1, N+2.
// CONFIGURATION
//  DUMP_PARITY_EN defined: extra state DUMP_PAR after DUMP_LO, io_out = shadow[15:8] ^ shadow[7:0],
//   then RUN; dump is 4 cycles.
//  DUMP_PARITY_EN undefined: DUMP_LO -> RUN; dump is 3 cycles; DUMP_PAR state does not exist.
// STRUCTURE
//  Package nibble_mac_pkg: state encoding (RUN, DUMP_HDR, DUMP_HI, DUMP_LO, DUMP_PAR), cmd codes
//   (CMD_ACC/HOLD/CLEAR/DUMP), ACC_W, HDR_HI.
//  Sub-module mac_sat_adder: 16-bit acc + 8-bit p -> clamped 16-bit sum + overflow flag; pure
//   combinational; the FSM and registers stay in the top.
// TESTING
//  1. Reset; cmd=00; nibbles 3,7,0 on consecutive cycles; then cmd=01 -> io_out=0x15, stays 0x15.
//  2. acc=0x15; cmd=11 one cycle, then cmd=00 with nibble 15 held -> io_out 0xA4,0x00,0x15,
//     then RUN; acc advanced by 0 during dump, resumes +225/cycle after.
//  3. Nibble 15 held, cmd=00 for 300 cycles -> io_out=0xFF; dump gives 0xA5,0xFF,0xFF.
//  4. After test 3, cmd=10 one cycle -> io_out=0x00; next dump header 0xA4 (ovf cleared).
//  5. Reset asserted during DUMP_HI -> io_out=0x00 next cycle; cmd=11 later starts fresh dump.
//  6. DUMP_PARITY_EN, acc=0x1234 -> dump 0xA4,0x12,0x34,0x26, then RUN; without macro 3 bytes.

Source files
------------

// File: rtl/nibble_mac_accumulator_pkg.sv
// Shared types and constants for the nibble MAC accumulator (FSM states, host commands, dump header).
// DUMP_PARITY_EN adds the DUMP_PAR state to the dump sequence.
package nibble_mac_pkg;

  localparam int unsigned ACC_W  = 16;
  localparam logic [6:0]  HDR_HI = 7'h52;

  typedef enum logic [1:0] {
    CMD_ACC   = 2'b00,
    CMD_HOLD  = 2'b01,
    CMD_CLEAR = 2'b10,
    CMD_DUMP  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    DUMP_HDR = 3'd1,
    DUMP_HI  = 3'd2,
`ifdef DUMP_PARITY_EN
    DUMP_LO  = 3'd3,
    DUMP_PAR = 3'd4
`else
    DUMP_LO  = 3'd3
`endif
  } state_e;

endpackage

// File: rtl/nibble_mac_accumulator_if.sv
// Host-side bus of the accumulator: command and operand nibble in, output byte back.
// Always valid every cycle; there is no backpressure.
interface nibble_mac_accumulator_if;
  logic [1:0] i_cmd;
  logic [3:0] i_nib;
  logic [7:0] o_out;

  modport master (output i_cmd, output i_nib, input  o_out);
  modport slave  (input  i_cmd, input  i_nib, output o_out);
endinterface

// File: rtl/nibble_mac_accumulator_sat_adder.sv
// Saturating accumulate: 16-bit acc + 8-bit product, clamped at 0xFFFF; purely combinational.
// Overflow flags only a true carry-out, so landing exactly on 0xFFFF is not an overflow.
module mac_sat_adder
  import nibble_mac_pkg::*;
(
  input  logic [ACC_W-1:0] i_acc,
  input  logic [7:0]       i_p,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_ovf
);

  logic [ACC_W:0] w_sum;

  assign w_sum = {1'b0, i_acc} + {{(ACC_W-7){1'b0}}, i_p};
  assign o_ovf = w_sum[ACC_W];
  assign o_sum = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

endmodule

// File: rtl/nibble_mac_accumulator.sv
// Nibble-pair MAC into a saturating 16-bit acc; io_out = acc[7:0], or header/hi/lo(/parity) on dump (DUMP_PARITY_EN).
// Dump header appears one cycle after CMD_DUMP is sampled; no backpressure, commands ignored while dumping.
module nibble_mac_accumulator
  import nibble_mac_pkg::*;
(
  input  logic                      i_clk,
  input  logic                      i_rst,
  nibble_mac_accumulator_if.slave   bus
);

  state_e           r_state;
  logic [3:0]       r_nib_q;
  logic [3:0]       r_nib_prev_q;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_shadow;
  logic             r_ovf;

  logic [7:0]       w_p;
  logic [ACC_W-1:0] w_sum;
  logic             w_carry;

  assign w_p = {4'b0, r_nib_q} * {4'b0, r_nib_prev_q};

  mac_sat_adder u_sat_adder (
    .i_acc (r_acc),
    .i_p   (w_p),
    .o_sum (w_sum),
    .o_ovf (w_carry)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= RUN;
      r_nib_q      <= '0;
      r_nib_prev_q <= '0;
      r_acc        <= '0;
      r_shadow     <= '0;
      r_ovf        <= 1'b0;
    end else begin
      // The operand pipe keeps streaming in every state, including mid-dump.
      r_nib_q      <= bus.i_nib;
      r_nib_prev_q <= r_nib_q;
      case (r_state)
        RUN: begin
          case (cmd_e'(bus.i_cmd))
            CMD_ACC: begin
              r_acc <= w_sum;
              r_ovf <= r_ovf | w_carry;
            end
            CMD_CLEAR: begin
              r_acc <= '0;
              r_ovf <= 1'b0;
            end
            CMD_DUMP: begin
              r_shadow <= r_acc;
              r_state  <= DUMP_HDR;
            end
            default: ;
          endcase
        end
        DUMP_HDR: r_state <= DUMP_HI;
        DUMP_HI:  r_state <= DUMP_LO;
`ifdef DUMP_PARITY_EN
        DUMP_LO:  r_state <= DUMP_PAR;
        DUMP_PAR: r_state <= RUN;
`else
        DUMP_LO:  r_state <= RUN;
`endif
        default:  r_state <= RUN;
      endcase
    end
  end

  always_comb begin
    bus.o_out = r_acc[7:0];
    case (r_state)
      DUMP_HDR: bus.o_out = {HDR_HI, r_ovf};
      DUMP_HI:  bus.o_out = r_shadow[15:8];
      DUMP_LO:  bus.o_out = r_shadow[7:0];
`ifdef DUMP_PARITY_EN
      DUMP_PAR: bus.o_out = r_shadow[15:8] ^ r_shadow[7:0];
`endif
      default:  bus.o_out = r_acc[7:0];
    endcase
  end

endmodule

// File: tb/tb_nibble_mac_accumulator.sv
// Bench for nibble_mac_accumulator: reference model of the MAC plus a queue of pending dump bytes,
// compared every negedge, with literal checks from hand-computed scenarios and randomized traffic.
module tb_nibble_mac_accumulator;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  bit   chk_en;

  nibble_mac_accumulator_if bus();

  nibble_mac_accumulator dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: accumulator as a plain integer, dump as a list of bytes still to be shown.
  int unsigned m_acc;
  bit          m_ovf;
  int unsigned m_nq;
  int unsigned m_np;
  logic [7:0]  m_dump[$];

  function automatic logic [7:0] model_out();
    if (m_dump.size() > 0) return m_dump[0];
    return m_acc[7:0];
  endfunction

  task automatic model_step(input bit r, input logic [1:0] c, input logic [3:0] n);
    int unsigned s;
    logic [7:0]  hi;
    logic [7:0]  lo;
    if (r) begin
      m_acc = 0; m_ovf = 0; m_nq = 0; m_np = 0;
      m_dump.delete();
      return;
    end
    if (m_dump.size() > 0) begin
      void'(m_dump.pop_front());
    end else begin
      case (c)
        2'b00: begin
          s = m_acc + m_nq * m_np;
          if (s > 65535) begin
            m_acc = 65535;
            m_ovf = 1;
          end else begin
            m_acc = s;
          end
        end
        2'b10: begin m_acc = 0; m_ovf = 0; end
        2'b11: begin
          hi = m_acc[15:8];
          lo = m_acc[7:0];
          m_dump.push_back(m_ovf ? 8'hA5 : 8'hA4);
          m_dump.push_back(hi);
          m_dump.push_back(lo);
`ifdef DUMP_PARITY_EN
          m_dump.push_back(hi ^ lo);
`endif
        end
        default: ;
      endcase
    end
    m_np = m_nq;
    m_nq = n;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (bus.o_out !== model_out()) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t got=%02h exp=%02h", $time, bus.o_out, model_out());
      end
    end
  end

  // One clock: drive inputs, advance the model at the edge, release 1 time unit later.
  task automatic cyc(input bit r, input logic [1:0] c, input logic [3:0] n);
    rst       = r;
    bus.i_cmd = c;
    bus.i_nib = n;
    @(posedge clk);
    model_step(r, c, n);
    #1;
  endtask

  task automatic lit(input string name, input logic [7:0] exp);
    n_tests++;
    if (bus.o_out !== exp) begin
      n_fail++;
      $display("FAIL %s got=%02h exp=%02h", name, bus.o_out, exp);
    end
  endtask

  task automatic add_prod(input logic [3:0] a, input logic [3:0] b);
    cyc(0, 2'b01, a);
    cyc(0, 2'b01, b);
    cyc(0, 2'b00, 4'd0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; chk_en = 0;
    m_acc = 0; m_ovf = 0; m_nq = 0; m_np = 0;
    rst = 1; bus.i_cmd = 2'b01; bus.i_nib = 4'd0;
    cyc(1, 2'b01, 4'd0);
    chk_en = 1;
    lit("reset_out", 8'h00);

    // 1: 3,7,0 streamed while accumulating -> 3*7
    cyc(0, 2'b00, 4'd3);
    cyc(0, 2'b00, 4'd7);
    cyc(0, 2'b00, 4'd0);
    lit("acc_3x7", 8'h15);
    cyc(0, 2'b01, 4'd5);
    cyc(0, 2'b01, 4'd6);
    lit("hold", 8'h15);

    // 2: dump then resume with nibble 15 held
    cyc(0, 2'b11, 4'd15);
    lit("dump_hdr", 8'hA4);
    cyc(0, 2'b00, 4'd15);
    lit("dump_hi", 8'h00);
    cyc(0, 2'b00, 4'd15);
    lit("dump_lo", 8'h15);
    cyc(0, 2'b00, 4'd15);
`ifdef DUMP_PARITY_EN
    lit("dump_par", 8'h15);
    cyc(0, 2'b00, 4'd15);
`endif
    lit("back_run", 8'h15);
    cyc(0, 2'b00, 4'd15);
    lit("resume_225", 8'hF6);

    // 3: saturate
    for (int i = 0; i < 300; i++) cyc(0, 2'b00, 4'd15);
    lit("sat_low", 8'hFF);
    cyc(0, 2'b11, 4'd15);
    lit("sat_hdr", 8'hA5);
    cyc(0, 2'b10, 4'd15);
    lit("sat_hi", 8'hFF);
    cyc(0, 2'b10, 4'd15);
    lit("sat_lo", 8'hFF);
    while (m_dump.size() > 0) cyc(0, 2'b01, 4'd15);

    // 4: clear drops ovf
    cyc(0, 2'b10, 4'd15);
    lit("clear", 8'h00);
    cyc(0, 2'b11, 4'd0);
    lit("clr_hdr", 8'hA4);
    while (m_dump.size() > 0) cyc(0, 2'b01, 4'd0);

    // 5: reset during DUMP_HI
    add_prod(4'd9, 4'd9);
    cyc(0, 2'b11, 4'd0);
    cyc(0, 2'b01, 4'd0);
    lit("mid_hi", 8'h00);
    cyc(1, 2'b01, 4'd0);
    lit("mid_rst", 8'h00);
    add_prod(4'd2, 4'd3);
    cyc(0, 2'b11, 4'd0);
    lit("fresh_hdr", 8'hA4);
    cyc(0, 2'b01, 4'd0);
    cyc(0, 2'b01, 4'd0);
    lit("fresh_lo", 8'h06);
    while (m_dump.size() > 0) cyc(0, 2'b01, 4'd0);

    // 6: acc = 0x1234 = 20*225 + 144 + 16
    cyc(0, 2'b10, 4'd0);
    for (int i = 0; i < 20; i++) add_prod(4'd15, 4'd15);
    add_prod(4'd12, 4'd12);
    add_prod(4'd4, 4'd4);
    lit("acc_1234", 8'h34);
    cyc(0, 2'b11, 4'd0);
    lit("p_hdr", 8'hA4);
    cyc(0, 2'b01, 4'd0);
    lit("p_hi", 8'h12);
    cyc(0, 2'b01, 4'd0);
    lit("p_lo", 8'h34);
    cyc(0, 2'b01, 4'd0);
`ifdef DUMP_PARITY_EN
    lit("p_par", 8'h26);
    cyc(0, 2'b01, 4'd0);
`endif
    lit("p_run", 8'h34);

    // Randomized: first a no-clear phase that drives into saturation, then a full mix.
    for (int i = 0; i < 2500; i++) begin
      int unsigned k;
      k = $urandom_range(0, 15);
      cyc(0, (k < 11) ? 2'b00 : (k < 14) ? 2'b01 : 2'b11, 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 3000; i++) begin
      int unsigned k;
      k = $urandom_range(0, 15);
      cyc(($urandom_range(0, 199) == 0), 2'(k % 4), 4'($urandom_range(0, 15)));
    end

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
